// File: rtl/instr_fetch_decode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// instr_fetch_decode : PC sequencer, program-memory fetch and decode for
//                      alu_mod; resolves JMP/JZ/JNZ/HALT locally.
// Revision 1.0
// ---------------------------------------------------------------------------
module instr_fetch_decode #(
  parameter  int WIDTH       = 8,
  parameter  int IWIDTH      = 8,
  parameter  int SOURCES     = 4,
  parameter  int ADDR_WIDTH  = 8,
  parameter  int PC_WIDTH    = 6,
  localparam int SW          = $clog2(SOURCES),
  localparam int INSTR_WIDTH = IWIDTH + 2*WIDTH + ADDR_WIDTH + 2*SW + 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  output logic [PC_WIDTH-1:0]    pm_addr,
  output logic                   pm_re,
  input  logic [INSTR_WIDTH-1:0] pm_data,
  input  logic                   zero_flag,
  output logic [IWIDTH-1:0]      op_code,
  output logic [WIDTH-1:0]       source1,
  output logic [WIDTH-1:0]       source2,
  output logic [SW-1:0]          source1_choice,
  output logic [SW-1:0]          source2_choice,
  output logic [ADDR_WIDTH-1:0]  destination,
  output logic [1:0]             dest_choice,
  output logic                   push,
  output logic                   pop,
  output logic [PC_WIDTH-1:0]    instr_addr,
  output logic                   issue_valid,
  output logic                   halted
);

  localparam int P_POP  = 1;
  localparam int P_PUSH = 2;
  localparam int P_DC   = 3;
  localparam int P_C2   = 5;
  localparam int P_C1   = P_C2 + SW;
  localparam int P_DEST = P_C1 + SW;
  localparam int P_S2   = P_DEST + ADDR_WIDTH;
  localparam int P_S1   = P_S2 + WIDTH;
  localparam int P_OP   = P_S1 + WIDTH;

  localparam logic [IWIDTH-1:0] OP_NOP  = IWIDTH'('h00);
  localparam logic [IWIDTH-1:0] OP_JMP  = IWIDTH'('h20);
  localparam logic [IWIDTH-1:0] OP_JZ   = IWIDTH'('h21);
  localparam logic [IWIDTH-1:0] OP_JNZ  = IWIDTH'('h22);
  localparam logic [IWIDTH-1:0] OP_HALT = IWIDTH'('hFF);

  localparam logic [1:0] DC_NONE = 2'b11;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [PC_WIDTH-1:0]   pm_addr_q, pm_addr_d;
  logic                  pm_re_q, pm_re_d;
  logic [IWIDTH-1:0]     op_code_q, op_code_d;
  logic [WIDTH-1:0]      source1_q, source1_d;
  logic [WIDTH-1:0]      source2_q, source2_d;
  logic [SW-1:0]         source1_choice_q, source1_choice_d;
  logic [SW-1:0]         source2_choice_q, source2_choice_d;
  logic [ADDR_WIDTH-1:0] destination_q, destination_d;
  logic [1:0]            dest_choice_q, dest_choice_d;
  logic                  push_q, push_d;
  logic                  pop_q, pop_d;
  logic [PC_WIDTH-1:0]   instr_addr_q, instr_addr_d;
  logic                  issue_valid_q, issue_valid_d;
  logic                  halted_q, halted_d;

  logic [IWIDTH-1:0]     w_op;
  logic [ADDR_WIDTH-1:0] w_dest;
  logic [PC_WIDTH-1:0]   w_target;
  logic [PC_WIDTH-1:0]   w_pc_inc;
  logic                  w_unused_reserved;

  assign w_op              = pm_data[P_OP +: IWIDTH];
  assign w_dest            = pm_data[P_DEST +: ADDR_WIDTH];
  assign w_target          = w_dest[PC_WIDTH-1:0];
  assign w_pc_inc          = pc_q + PC_WIDTH'(1);
  assign w_unused_reserved = pm_data[0];

  // The issue-output registers double as the instruction register: the
  // memory word is decoded straight into them on the cycle it is valid.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    pm_addr_d        = pm_addr_q;
    pm_re_d          = 1'b0;
    op_code_d        = OP_NOP;
    source1_d        = '0;
    source2_d        = '0;
    source1_choice_d = '0;
    source2_choice_d = '0;
    destination_d    = '0;
    dest_choice_d    = DC_NONE;
    push_d           = 1'b0;
    pop_d            = 1'b0;
    instr_addr_d     = instr_addr_q;
    issue_valid_d    = 1'b0;
    halted_d         = halted_q;

    case (state_q)
      S_FETCH: begin
        if (!stall) begin
          pm_addr_d = pc_q;
          pm_re_d   = 1'b1;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        issue_valid_d = 1'b1;
        instr_addr_d  = pc_q;
        state_d       = S_FETCH;
        pc_d          = w_pc_inc;
        case (w_op)
          OP_NOP: ;
          OP_JMP: pc_d = w_target;
          OP_JZ:  if (zero_flag)  pc_d = w_target;
          OP_JNZ: if (!zero_flag) pc_d = w_target;
          OP_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          default: begin
            op_code_d        = w_op;
            source1_d        = pm_data[P_S1 +: WIDTH];
            source2_d        = pm_data[P_S2 +: WIDTH];
            source1_choice_d = pm_data[P_C1 +: SW];
            source2_choice_d = pm_data[P_C2 +: SW];
            destination_d    = w_dest;
            dest_choice_d    = pm_data[P_DC +: 2];
            push_d           = pm_data[P_PUSH];
            pop_d            = pm_data[P_POP];
          end
        endcase
      end
      S_HALT: begin
        halted_d = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= S_FETCH;
      pc_q             <= '0;
      pm_addr_q        <= '0;
      pm_re_q          <= 1'b0;
      op_code_q        <= OP_NOP;
      source1_q        <= '0;
      source2_q        <= '0;
      source1_choice_q <= '0;
      source2_choice_q <= '0;
      destination_q    <= '0;
      dest_choice_q    <= DC_NONE;
      push_q           <= 1'b0;
      pop_q            <= 1'b0;
      instr_addr_q     <= '0;
      issue_valid_q    <= 1'b0;
      halted_q         <= 1'b0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      pm_addr_q        <= pm_addr_d;
      pm_re_q          <= pm_re_d;
      op_code_q        <= op_code_d;
      source1_q        <= source1_d;
      source2_q        <= source2_d;
      source1_choice_q <= source1_choice_d;
      source2_choice_q <= source2_choice_d;
      destination_q    <= destination_d;
      dest_choice_q    <= dest_choice_d;
      push_q           <= push_d;
      pop_q            <= pop_d;
      instr_addr_q     <= instr_addr_d;
      issue_valid_q    <= issue_valid_d;
      halted_q         <= halted_d;
    end
  end

  assign pm_addr        = pm_addr_q;
  assign pm_re          = pm_re_q;
  assign op_code        = op_code_q;
  assign source1        = source1_q;
  assign source2        = source2_q;
  assign source1_choice = source1_choice_q;
  assign source2_choice = source2_choice_q;
  assign destination    = destination_q;
  assign dest_choice    = dest_choice_q;
  assign push           = push_q;
  assign pop            = pop_q;
  assign instr_addr     = instr_addr_q;
  assign issue_valid    = issue_valid_q;
  assign halted         = halted_q;

endmodule
`default_nettype wire
